axi_stream_len_parser: RTL and testbench

- Receive-side counterpart of axi_stream_len_prepender: consumes a 64-bit AXI-Stream whose first beat per packet is a length/ID header, and re-emits the payload with a regenerated tlast.
- Validates header ID, declared length against MAX_PKT_LEN, and declared length against actual in_tlast position; counts errors.
- Sits on the clk (125 MHz) domain between a stream source (loopback or UDP RX path) and the consumer FIFO.

---
 rtl/axi_stream_len_parser.sv | 156 +++++++++++++++
 tb/tb_axi_stream_len_parser.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_len_parser.sv
// Strips the length/ID header word from a 64-bit stream and re-emits the payload with a regenerated tlast.
// One registered output stage; header ID, declared length and actual tlast position are checked and counted.
module axi_stream_len_parser #(
   parameter logic [7:0]  ID          = 8'hF0,
   parameter int unsigned MAX_PKT_LEN = 64,
   parameter bit          CHECK_ID    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [63:0] in_tdata,
   input  logic        in_tvalid,
   input  logic        in_tlast,
   output logic        in_tready,
   output logic [63:0] out_tdata,
   output logic        out_tvalid,
   output logic        out_tlast,
   input  logic        out_tready,
   output logic [7:0]  pkt_id,
   output logic [15:0] pkt_len,
   output logic [31:0] pkt_count,
   output logic [15:0] err_id_count,
   output logic [15:0] err_len_count,
   input  logic        clear_counters
);

   typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DRAIN} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;

   logic        w_stage_free;
   logic        w_hs;
   logic [7:0]  w_hdr_id;
   logic [15:0] w_hdr_len;
   logic        w_id_bad;
   logic        w_len_over;
   logic        w_cnt_last;
   logic        w_fwd;
   logic        w_fwd_last;
   logic        w_inc_pkt;
   logic        w_inc_id;
   logic        w_inc_len;

   assign w_stage_free = !out_tvalid || out_tready;
   assign w_hdr_id     = in_tdata[63:56];
   assign w_hdr_len    = in_tdata[15:0];
   assign w_id_bad     = CHECK_ID && (w_hdr_id != ID);
   assign w_len_over   = ({16'd0, w_hdr_len} > MAX_PKT_LEN);
   assign w_cnt_last   = (r_cnt == 16'd1);
   assign w_hs         = in_tvalid && in_tready;

   assign in_tready = !rst && (((r_state == S_HDR) && ena) ||
                               ((r_state == S_PAYLOAD) && w_stage_free) ||
                               (r_state == S_DRAIN));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_HDR;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_HDR: begin
            if (w_hs) begin
               if (w_id_bad || w_len_over || (w_hdr_len == 16'd0))
                  w_next = in_tlast ? S_HDR : S_DRAIN;
               else if (!in_tlast)
                  w_next = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (w_hs) begin
               if (in_tlast)        w_next = S_HDR;
               else if (w_cnt_last) w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_hs && in_tlast) w_next = S_HDR;
         end
         default: w_next = S_HDR;
      endcase
   end

   // Exactly one counter event per header or terminating payload beat.
   always_comb begin
      w_fwd      = 1'b0;
      w_fwd_last = 1'b0;
      w_inc_pkt  = 1'b0;
      w_inc_id   = 1'b0;
      w_inc_len  = 1'b0;
      case (r_state)
         S_HDR: begin
            if (w_hs) begin
               if (w_id_bad)                   w_inc_id  = 1'b1;
               else if (w_len_over)            w_inc_len = 1'b1;
               else if (w_hdr_len == 16'd0) begin
                  if (in_tlast)                w_inc_pkt = 1'b1;
                  else                         w_inc_len = 1'b1;
               end
               else if (in_tlast)              w_inc_len = 1'b1;
            end
         end
         S_PAYLOAD: begin
            if (w_hs) begin
               w_fwd      = 1'b1;
               w_fwd_last = in_tlast || w_cnt_last;
               if (in_tlast && w_cnt_last)     w_inc_pkt = 1'b1;
               else if (in_tlast || w_cnt_last) w_inc_len = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_tdata     <= '0;
         out_tvalid    <= 1'b0;
         out_tlast     <= 1'b0;
         pkt_id        <= '0;
         pkt_len       <= '0;
         r_cnt         <= '0;
         pkt_count     <= '0;
         err_id_count  <= '0;
         err_len_count <= '0;
      end else begin
         if (w_stage_free) begin
            out_tvalid <= w_fwd;
            if (w_fwd) begin
               out_tdata <= in_tdata;
               out_tlast <= w_fwd_last;
            end
         end
         if ((r_state == S_HDR) && w_hs) begin
            pkt_id  <= w_hdr_id;
            pkt_len <= w_hdr_len;
            r_cnt   <= w_hdr_len;
         end else if (w_fwd) begin
            r_cnt <= r_cnt - 16'd1;
         end
         if (clear_counters) begin
            pkt_count     <= '0;
            err_id_count  <= '0;
            err_len_count <= '0;
         end else begin
            if (w_inc_pkt && !(&pkt_count))     pkt_count     <= pkt_count + 32'd1;
            if (w_inc_id  && !(&err_id_count))  err_id_count  <= err_id_count + 16'd1;
            if (w_inc_len && !(&err_len_count)) err_len_count <= err_len_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_len_parser.sv
// Randomized bench: a packet-level model predicts forwarded words and counter values.
module tb_axi_stream_len_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst1 = 1'b1;
   logic        ena = 1'b0;
   logic [63:0] in_tdata = '0;
   logic        in_tvalid = 1'b0;
   logic        in_tlast = 1'b0;
   logic        in_tready;
   logic [63:0] out_tdata;
   logic        out_tvalid;
   logic        out_tlast;
   logic        out_tready = 1'b0;
   logic [7:0]  pkt_id;
   logic [15:0] pkt_len;
   logic [31:0] pkt_count;
   logic [15:0] err_id_count;
   logic [15:0] err_len_count;
   logic        clear_counters = 1'b0;

   logic        in_tready1;
   logic [63:0] out1_tdata;
   logic        out1_tvalid;
   logic        out1_tlast;
   logic [7:0]  pkt_id1;
   logic [15:0] pkt_len1;
   logic [31:0] pkt_count1;
   logic [15:0] err_id_count1;
   logic [15:0] err_len_count1;

   int vectors = 0;
   int miscompares = 0;
   int rdy_mode = 0;
   bit ena_rand = 0;
   int m_pkt = 0, m_id = 0, m_len = 0;

   logic [63:0] q_dat[$];
   logic        q_last[$];
   logic [63:0] q1_dat[$];
   logic        q1_last[$];
   logic [63:0] e_dat[$];
   logic        e_last[$];

   always #4 clk = ~clk;

   axi_stream_len_parser u_dut (
      .clk(clk), .rst(rst), .ena(ena),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
      .pkt_id(pkt_id), .pkt_len(pkt_len), .pkt_count(pkt_count),
      .err_id_count(err_id_count), .err_len_count(err_len_count), .clear_counters(clear_counters)
   );

   axi_stream_len_parser #(.CHECK_ID(1'b0)) u_dut_noid (
      .clk(clk), .rst(rst1), .ena(ena),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready1),
      .out_tdata(out1_tdata), .out_tvalid(out1_tvalid), .out_tlast(out1_tlast), .out_tready(out_tready),
      .pkt_id(pkt_id1), .pkt_len(pkt_len1), .pkt_count(pkt_count1),
      .err_id_count(err_id_count1), .err_len_count(err_len_count1), .clear_counters(clear_counters)
   );

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = ~out_tready;
            default: out_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: records transfers and checks that a stalled beat is held.
   initial begin
      logic        prev_stall;
      logic [63:0] prev_d;
      logic        prev_l;
      prev_stall = 1'b0;
      prev_d = '0;
      prev_l = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && prev_stall) begin
            vectors++;
            if (out_tvalid !== 1'b1 || out_tdata !== prev_d || out_tlast !== prev_l) begin
               miscompares++;
               $display("FAIL stall_hold: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                        out_tvalid, out_tdata, out_tlast, prev_d, prev_l);
            end
         end
         if (!rst && out_tvalid && out_tready) begin
            q_dat.push_back(out_tdata);
            q_last.push_back(out_tlast);
         end
         if (!rst1 && out1_tvalid && out_tready) begin
            q1_dat.push_back(out1_tdata);
            q1_last.push_back(out1_tlast);
         end
         prev_stall = !rst && out_tvalid && !out_tready;
         prev_d = out_tdata;
         prev_l = out_tlast;
      end
   end

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // Entered and left at posedge+1; returns once the word has been accepted.
   task automatic send_word(input logic [63:0] d, input logic last, input int gap_max);
      int to;
      repeat ($urandom_range(0, gap_max)) begin
         in_tvalid = 1'b0;
         @(posedge clk); #1;
      end
      in_tvalid = 1'b1;
      in_tdata  = d;
      in_tlast  = last;
      to = 0;
      while (1) begin
         @(negedge clk);
         if (in_tready) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         if (ena_rand) ena = ($urandom_range(0, 3) != 0);
         to++;
         if (to > 500) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: got no in_tready within %0d cycles want ready", to);
            break;
         end
      end
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
   endtask

   // Packet-level reference: what a correct parser forwards and counts for this packet.
   task automatic send_pkt(input logic [7:0] id, input logic [15:0] len, input int n_pay, input int gap);
      logic [63:0] w[$];
      int k;
      for (int i = 0; i < n_pay; i++) w.push_back({$urandom, $urandom});
      send_word({id, 8'h5A, $urandom, len}, n_pay == 0, gap);
      for (int i = 0; i < n_pay; i++) send_word(w[i], i == n_pay - 1, gap);
      if (id != 8'hF0)       m_id++;
      else if (len > 16'd64) m_len++;
      else if (len == 16'd0) begin
         if (n_pay == 0) m_pkt++;
         else            m_len++;
      end
      else if (n_pay == 0)   m_len++;
      else begin
         k = (n_pay < int'(len)) ? n_pay : int'(len);
         for (int i = 0; i < k; i++) begin
            e_dat.push_back(w[i]);
            e_last.push_back(i == k - 1);
         end
         if (n_pay == int'(len)) m_pkt++;
         else                    m_len++;
      end
   endtask

   task automatic check_results(input string name);
      int n;
      rdy_mode  = 0;
      ena_rand  = 0;
      ena       = 1'b1;
      in_tvalid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      vectors++;
      if (q_dat.size() !== e_dat.size()) begin
         miscompares++;
         $display("FAIL %s_beats: got %0d want %0d", name, q_dat.size(), e_dat.size());
      end
      n = (q_dat.size() < e_dat.size()) ? q_dat.size() : e_dat.size();
      for (int i = 0; i < n; i++) begin
         vectors++;
         if (q_dat[i] !== e_dat[i] || q_last[i] !== e_last[i]) begin
            miscompares++;
            $display("FAIL %s_beat%0d: got %h/%0b want %h/%0b", name, i, q_dat[i], q_last[i], e_dat[i], e_last[i]);
         end
      end
      vectors++;
      if (pkt_count !== 32'(m_pkt)) begin
         miscompares++;
         $display("FAIL %s_pkt_count: got %0d want %0d", name, pkt_count, m_pkt);
      end
      vectors++;
      if (err_id_count !== 16'(sat16(m_id))) begin
         miscompares++;
         $display("FAIL %s_err_id: got %0d want %0d", name, err_id_count, sat16(m_id));
      end
      vectors++;
      if (err_len_count !== 16'(sat16(m_len))) begin
         miscompares++;
         $display("FAIL %s_err_len: got %0d want %0d", name, err_len_count, sat16(m_len));
      end
      q_dat.delete(); q_last.delete(); e_dat.delete(); e_last.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (in_tready !== 1'b0 || out_tvalid !== 1'b0 || out_tlast !== 1'b0 || out_tdata !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%0b v=%0b l=%0b d=%h want 0/0/0/0", in_tready, out_tvalid, out_tlast, out_tdata);
      end
      vectors++;
      if (pkt_count !== 32'd0 || err_id_count !== 16'd0 || err_len_count !== 16'd0 || pkt_id !== 8'd0 || pkt_len !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_counters: got %0d/%0d/%0d id=%h len=%0d want zeros", pkt_count, err_id_count, err_len_count, pkt_id, pkt_len);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      ena = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_tready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %0b want 1", in_tready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [63:0] d;
      rdy_mode = 0;
      send_word({8'hF0, 40'h0, 16'd4}, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         d = 64'hD0D0_0000_0000_0000 + 64'(i);
         send_word(d, i == 3, 0);
         e_dat.push_back(d);
         e_last.push_back(i == 3);
         vectors++;
         if (out_tvalid !== 1'b1 || out_tdata !== d || out_tlast !== (i == 3)) begin
            miscompares++;
            $display("FAIL basic_latency%0d: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b", i, out_tvalid, out_tdata, out_tlast, d, i == 3);
         end
      end
      m_pkt++;
      vectors++;
      if (pkt_len !== 16'd4 || pkt_id !== 8'hF0) begin
         miscompares++;
         $display("FAIL basic_hdr_latch: got id=%h len=%0d want id=f0 len=4", pkt_id, pkt_len);
      end
      check_results("basic");
   endtask

   task automatic test_backpressure();
      rdy_mode = 1;
      send_pkt(8'hF0, 16'd4, 4, 2);
      send_pkt(8'hF0, 16'd7, 7, 1);
      check_results("toggle");
      rdy_mode = 2;
      for (int p = 0; p < 6; p++) send_pkt(8'hF0, 16'($urandom_range(1, 10)), 0, 0);
      for (int p = 0; p < 6; p++) begin
         int l;
         l = $urandom_range(1, 10);
         send_pkt(8'hF0, 16'(l), l, 2);
      end
      check_results("random_stall");
   endtask

   task automatic test_check_id();
      rdy_mode = 0;
      @(posedge clk); #1;
      rst1 = 1'b0;
      q1_dat.delete(); q1_last.delete();
      send_pkt(8'hAA, 16'd2, 2, 0);
      send_pkt(8'hF0, 16'd3, 3, 0);
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (q1_dat.size() !== 5 || q1_last.size() !== 5) begin
         miscompares++;
         $display("FAIL noid_beats: got %0d want 5", q1_dat.size());
      end else begin
         vectors++;
         if (q1_last[1] !== 1'b1 || q1_last[4] !== 1'b1 || q1_last[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL noid_tlast: got %0b%0b%0b want 011", q1_last[0], q1_last[1], q1_last[4]);
         end
      end
      vectors++;
      if (pkt_count1 !== 32'd2 || err_id_count1 !== 16'd0) begin
         miscompares++;
         $display("FAIL noid_counts: got pkt=%0d id=%0d want pkt=2 id=0", pkt_count1, err_id_count1);
      end
      rst1 = 1'b1;
      check_results("check_id");
   endtask

   task automatic test_len_errors();
      rdy_mode = 0;
      send_pkt(8'hF0, 16'd4, 2, 0);
      send_pkt(8'hF0, 16'd2, 5, 0);
      send_pkt(8'hF0, 16'd65, 65, 0);
      send_pkt(8'hF0, 16'd0, 0, 0);
      send_pkt(8'hF0, 16'd0, 2, 0);
      send_pkt(8'hF0, 16'd3, 0, 0);
      send_pkt(8'hF0, 16'd64, 64, 0);
      send_pkt(8'hF0, 16'd1, 1, 0);
      check_results("len_err");
   endtask

   task automatic test_random();
      rdy_mode = 2;
      ena_rand = 1;
      for (int p = 0; p < 40; p++) begin
         logic [7:0] id;
         int l, n, r;
         id = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hF0;
         r = $urandom_range(0, 9);
         l = (r == 0) ? 0 : (r == 1) ? $urandom_range(65, 70) : $urandom_range(1, 12);
         r = $urandom_range(0, 9);
         n = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 14) : l;
         send_pkt(id, 16'(l), n, 2);
      end
      check_results("random");
   endtask

   task automatic test_reset_mid();
      rdy_mode = 0;
      send_word({8'hF0, 40'h0, 16'd6}, 1'b0, 0);
      for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_tvalid !== 1'b0 || in_tready !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_valid: got v=%0b rdy=%0b want 0/0", out_tvalid, in_tready);
      end
      vectors++;
      if (pkt_count !== 32'd0 || err_id_count !== 16'd0 || err_len_count !== 16'd0) begin
         miscompares++;
         $display("FAIL rst_mid_counters: got %0d/%0d/%0d want 0/0/0", pkt_count, err_id_count, err_len_count);
      end
      rst = 1'b0;
      m_pkt = 0; m_id = 0; m_len = 0;
      q_dat.delete(); q_last.delete(); e_dat.delete(); e_last.delete();
      send_pkt(8'hF0, 16'd3, 3, 1);
      check_results("rst_mid");
   endtask

   task automatic test_saturate();
      int n;
      n = 65535 - m_id;
      in_tdata  = {8'h55, 40'h0, 16'd1};
      in_tlast  = 1'b1;
      in_tvalid = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      m_id += n;
      vectors++;
      if (err_id_count !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sat_reach: got %h want ffff", err_id_count);
      end
      @(posedge clk); #1;
      m_id++;
      vectors++;
      if (err_id_count !== 16'hFFFF || pkt_count !== 32'(m_pkt)) begin
         miscompares++;
         $display("FAIL sat_hold: got %h pkt=%0d want ffff pkt=%0d", err_id_count, pkt_count, m_pkt);
      end
      clear_counters = 1'b1;
      @(posedge clk); #1;
      clear_counters = 1'b0;
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      m_pkt = 0; m_id = 0; m_len = 0;
      vectors++;
      if (err_id_count !== 16'd0 || err_len_count !== 16'd0 || pkt_count !== 32'd0) begin
         miscompares++;
         $display("FAIL clear_priority: got %0d/%0d/%0d want 0/0/0", pkt_count, err_id_count, err_len_count);
      end
      send_pkt(8'hF0, 16'd2, 2, 0);
      check_results("after_clear");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_check_id();
      test_len_errors();
      test_random();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
